i2c_write_sequencer: RTL and testbench
======================================

// Module: i2c_write_sequencer
// PURPOSE
//  Upstream command stage for the byte-level I2C master engine. Accepts a write
//  transaction (7-bit slave address + N payload bytes buffered in an internal
//  FIFO) from the AXI-Lite register block and sequences the engine's
//  start/stop/tx_data/i2c_en handshake: START, address byte, N data bytes, STOP.
// PARAMETERS
//  FIFO_DEPTH  8   payload FIFO entries (power of two, >=2)
//  LEN_W       4   width of cmd_len; must hold FIFO_DEPTH
//  TIMEOUT_CYC 65535  watchdog limit in clk cycles (only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  cmd_start    in   1      pulse: begin transaction (accepted only when !busy)
//  cmd_addr     in   7      slave address, sampled on accepted cmd_start
//  cmd_len      in   LEN_W  payload byte count 0..FIFO_DEPTH, sampled with cmd_start
//  wr_data      in   8      payload byte to push
//  wr_valid     in   1      push wr_data into FIFO this cycle
//  fifo_full    out  1      FIFO holds FIFO_DEPTH bytes
//  fifo_ovf     out  1      1-cycle pulse: push dropped because FIFO full
//  busy         out  1      transaction in progress
//  done         out  1      1-cycle pulse: STOP completed, engine back in idle
//  err          out  1      1-cycle pulse: watchdog abort (0 when feature off)
//  i2c_tx_data  out  8      byte presented to engine
//  i2c_start    out  1      engine start request
//  i2c_stop     out  1      engine stop request
//  i2c_en       out  1      engine command strobe
//  i2c_ready    in   1      engine ready (level)
//  i2c_tx_done  in   1      engine byte-complete pulse
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, byte counter 0.
//  - Engine handshake: a command is i2c_en=1 for exactly one clk while i2c_ready=1;
//    i2c_start/i2c_stop/i2c_tx_data are valid in that same cycle and registered.
//    i2c_ready is not sampled in the cycle after a strobe (GUARD) so the engine
//    can leave its ready state. All other cycles: i2c_en=i2c_start=i2c_stop=0.
//  - States: IDLE -> ISSUE_START -> ADDR_GO -> WAIT_TXD -> WAIT_HOLD ->
//    {ISSUE_DATA -> WAIT_TXD | ISSUE_STOP -> WAIT_IDLE} -> IDLE.
//    IDLE: cmd_start & !busy latches addr/len, busy=1 next cycle.
//    ISSUE_START: on i2c_ready strobe en+start, tx_data={cmd_addr,1'b0}.
//    ADDR_GO: on i2c_ready strobe en only (releases engine into address byte).
//    WAIT_TXD: wait for i2c_tx_done pulse. WAIT_HOLD: wait for i2c_ready.
//    Then remaining>0: if FIFO non-empty strobe en with tx_data=FIFO head, pop
//    same cycle, remaining-1; if FIFO empty stall in WAIT_HOLD (engine holds SCL
//    low). remaining==0: strobe en+stop. WAIT_IDLE: on i2c_ready, done=1, busy=0.
//  - cmd_len=0: address-only write (START, addr, STOP).
//  - cmd_start while busy: ignored, no side effects.
//  - FIFO: push when wr_valid & !full; push+pop same cycle on full FIFO is
//    allowed (pop first). wr_valid & full & no pop -> drop, fifo_ovf=1.
//    Pointers wrap modulo FIFO_DEPTH; leftover bytes after done stay queued.
//  - Mid-operation reset returns everything to reset values immediately.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined: counter clears on every strobe/tx_done; if it
//   reaches TIMEOUT_CYC in any non-IDLE state, err=1 one cycle, FIFO flushed,
//   busy=0, state IDLE, no done. Not defined: no counter, err tied 0.
// TESTING
//  1. Push A5,3C; cmd_start addr=0x50 len=2 -> engine sees tx bytes A0,A5,3C then
//     stop strobe; done one pulse; busy 1->0; FIFO empty.
//  2. len=0 addr=0x27 -> single byte 4E then stop; done pulses.
//  3. len=2, push only 1 byte -> stall in WAIT_HOLD, i2c_en stays 0; push 2nd
//     byte 1000 clk later -> transaction resumes and completes.
//  4. Push 9 bytes at FIFO_DEPTH=8 -> fifo_full after 8th, fifo_ovf on 9th,
//     8 bytes retained; cmd_start during busy ignored (addr unchanged).
//  5. Assert reset mid data byte -> all outputs 0 next cycle, FIFO empty.
//  6. I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, hold i2c_ready=0 after start ->
//     err pulse at cycle 100, busy=0, FIFO flushed, no done.

Source files
------------

// File: rtl/i2c_write_sequencer_if.sv
// Engine-side handshake bundle between the write sequencer and the
// byte-level I2C master engine.
interface i2c_write_sequencer_if;
    logic [7:0] i2c_tx_data;
    logic       i2c_start;
    logic       i2c_stop;
    logic       i2c_en;
    logic       i2c_ready;
    logic       i2c_tx_done;

    modport master (
        output i2c_tx_data, i2c_start, i2c_stop, i2c_en,
        input  i2c_ready, i2c_tx_done
    );

    modport slave (
        input  i2c_tx_data, i2c_start, i2c_stop, i2c_en,
        output i2c_ready, i2c_tx_done
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// I2C write sequencer: buffers payload bytes in a small FIFO and walks the
// engine through START, address byte, N data bytes and STOP.
// Optional watchdog abort is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_write_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_start,
    input  logic [6:0]               cmd_addr,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     fifo_full,
    output logic                     fifo_ovf,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    i2c_write_sequencer_if.master    eng
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (FIFO_DEPTH >= (1 << LEN_W)) begin : g_bad_len
        $error("LEN_W too narrow to hold FIFO_DEPTH");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_START,
        ADDR_GO,
        WAIT_TXD,
        WAIT_HOLD,
        ISSUE_DATA,
        ISSUE_STOP,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [6:0]       addr_q;
    logic [LEN_W-1:0] remaining;
    logic             guard;
    logic             en_q, start_q, stop_q;
    logic [7:0]       tx_data_q;
    logic             busy_q, done_q, err_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             ovf_q;

    logic             ready_ok;
    logic             pop;
    logic             push;
    logic             timeout_hit;

    // Ready is ignored in the strobe cycle and the one after it so the
    // engine has time to drop out of its ready state.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        ready_ok   = eng.i2c_ready && !en_q && !guard;
        pop        = (state == WAIT_HOLD) && ready_ok && (remaining != '0)
                     && !fifo_empty && !timeout_hit;
        push       = wr_valid && (!fifo_full || pop) && !timeout_hit;
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;

    // Watchdog restarts on every engine strobe or byte completion while active
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (state == IDLE || timeout_hit || en_q || eng.i2c_tx_done)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    assign timeout_hit = (state != IDLE) && !en_q && !eng.i2c_tx_done
                         && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Payload storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else if (timeout_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= wr_valid && fifo_full && !pop;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Transaction sequencer with registered engine handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            guard     <= 1'b0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            guard   <= en_q;
            if (timeout_hit) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_start) begin
                            addr_q    <= cmd_addr;
                            remaining <= cmd_len;
                            busy_q    <= 1'b1;
                            state     <= ISSUE_START;
                        end
                    end
                    ISSUE_START: begin
                        if (ready_ok) begin
                            en_q      <= 1'b1;
                            start_q   <= 1'b1;
                            tx_data_q <= {addr_q, 1'b0};
                            state     <= ADDR_GO;
                        end
                    end
                    ADDR_GO: begin
                        if (ready_ok) begin
                            en_q  <= 1'b1;
                            state <= WAIT_TXD;
                        end
                    end
                    WAIT_TXD: begin
                        if (eng.i2c_tx_done)
                            state <= WAIT_HOLD;
                    end
                    WAIT_HOLD: begin
                        if (ready_ok) begin
                            if (remaining != '0) begin
                                // Empty FIFO: stay here, engine keeps SCL low
                                if (!fifo_empty) begin
                                    en_q      <= 1'b1;
                                    tx_data_q <= mem[rd_ptr];
                                    remaining <= remaining - LEN_W'(1);
                                    state     <= ISSUE_DATA;
                                end
                            end else begin
                                en_q   <= 1'b1;
                                stop_q <= 1'b1;
                                state  <= ISSUE_STOP;
                            end
                        end
                    end
                    ISSUE_DATA: state <= WAIT_TXD;
                    ISSUE_STOP: state <= WAIT_IDLE;
                    WAIT_IDLE: begin
                        if (ready_ok) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign fifo_ovf        = ovf_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign eng.i2c_en      = en_q;
    assign eng.i2c_start   = start_q;
    assign eng.i2c_stop    = stop_q;
    assign eng.i2c_tx_data = tx_data_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a behavioural engine model.
module tb_i2c_write_sequencer;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TCYC  = 100;
    localparam int          STALL = 50;
`else
    localparam int unsigned TCYC  = 65535;
    localparam int          STALL = 1000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_start;
    logic [6:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       fifo_full, fifo_ovf, busy, done, err;

    i2c_write_sequencer_if bus ();

    i2c_write_sequencer #(
        .FIFO_DEPTH (8),
        .LEN_W      (4),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_start(cmd_start),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .fifo_full(fifo_full),
        .fifo_ovf (fifo_ovf),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .eng      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Engine log entries: {start, stop, tx_data}
    logic [9:0] lg[$];
    logic       eng_on = 1'b0;
    logic       eng_freeze = 1'b0;
    int         eng_kind;
    int         eng_cnt;

    // Engine model: ready when idle, drops ready on a strobe, returns after a delay
    initial begin
        bus.i2c_ready   = 1'b0;
        bus.i2c_tx_done = 1'b0;
        eng_kind = 0;
        eng_cnt  = 0;
        forever begin
            @(negedge clk);
            bus.i2c_tx_done = 1'b0;
            if (reset || !eng_on) begin
                bus.i2c_ready = 1'b0;
                eng_kind = 0;
                eng_cnt  = 0;
            end else if (eng_kind == 0) begin
                bus.i2c_ready = 1'b1;
                if (bus.i2c_en) begin
                    lg.push_back({bus.i2c_start, bus.i2c_stop, bus.i2c_tx_data});
                    bus.i2c_ready = 1'b0;
                    if (bus.i2c_start) begin
                        eng_kind = 1; eng_cnt = 2;
                    end else if (bus.i2c_stop) begin
                        eng_kind = 3; eng_cnt = 3;
                    end else begin
                        eng_kind = 2; eng_cnt = 5;
                    end
                end
            end else if (!(eng_kind == 1 && eng_freeze)) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    if (eng_kind == 2)
                        bus.i2c_tx_done = 1'b1;
                    bus.i2c_ready = 1'b1;
                    eng_kind = 0;
                end
            end
        end
    end

    // Pulse counters
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lg.delete();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_data  = b;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic [6:0] a, input logic [3:0] n);
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = n;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output logic busy_at_done);
        ok = 1'b0;
        busy_at_done = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (lg.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        v = {busy, done, err, fifo_full, fifo_ovf, bus.i2c_en, bus.i2c_start, bus.i2c_stop, bus.i2c_tx_data};
        checks++;
        if (v !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", v);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        v = {busy, done, err, fifo_full, fifo_ovf, bus.i2c_en, bus.i2c_start, bus.i2c_stop, bus.i2c_tx_data};
        checks++;
        if (v !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_outputs: got %h expected 0000", v);
        end
    endtask

    task automatic test_basic_write();
        logic [9:0] exp_l[5] = '{10'h2A0, 10'h0A0, 10'h0A5, 10'h03C, 10'h100};
        bit ok;
        logic b;
        int d0;
        do_reset();
        eng_on = 1'b1;
        push_byte(8'hA5);
        push_byte(8'h3C);
        d0 = done_cnt;
        issue_cmd(7'h50, 4'd2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_set: got %b expected 1", busy);
        end
        wait_done(500, ok, b);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_seen: got timeout expected done pulse");
        end
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_clear: got %b expected 0", b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (lg.size() != 5) begin
            errors++;
            $display("FAIL basic_log_len: got %0d expected 5", lg.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if ((lg[k] & (exp_l[k][8] ? 10'h300 : 10'h3FF)) !== exp_l[k]) begin
                    errors++;
                    $display("FAIL basic_log[%0d]: got %h expected %h", k, lg[k], exp_l[k]);
                end
            end
        end
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL basic_fifo_full: got %b expected 0", fifo_full);
        end
    endtask

    task automatic test_addr_only();
        logic [9:0] exp_l[3] = '{10'h24E, 10'h04E, 10'h100};
        bit ok;
        logic b;
        do_reset();
        issue_cmd(7'h27, 4'd0);
        wait_done(500, ok, b);
        checks++;
        if (!ok || b !== 1'b0) begin
            errors++;
            $display("FAIL addr_only_done: got ok=%b busy=%b expected ok=1 busy=0", ok, b);
        end
        checks++;
        if (lg.size() != 3) begin
            errors++;
            $display("FAIL addr_only_log_len: got %0d expected 3", lg.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ((lg[k] & (exp_l[k][8] ? 10'h300 : 10'h3FF)) !== exp_l[k]) begin
                    errors++;
                    $display("FAIL addr_only_log[%0d]: got %h expected %h", k, lg[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [9:0] exp_l[5] = '{10'h274, 10'h074, 10'h011, 10'h022, 10'h100};
        bit ok;
        logic b;
        int en_seen;
        do_reset();
        push_byte(8'h11);
        issue_cmd(7'h3A, 4'd2);
        wait_log(3, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_first_data: got timeout expected 3 strobes");
        end
        en_seen = 0;
        for (int i = 0; i < STALL; i++) begin
            @(negedge clk);
            if (bus.i2c_en) en_seen++;
        end
        checks++;
        if (en_seen != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got en_count=%0d busy=%b expected 0 and 1", en_seen, busy);
        end
        push_byte(8'h22);
        wait_done(500, ok, b);
        checks++;
        if (!ok || b !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume_done: got ok=%b busy=%b expected ok=1 busy=0", ok, b);
        end
        checks++;
        if (lg.size() != 5) begin
            errors++;
            $display("FAIL stall_log_len: got %0d expected 5", lg.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if ((lg[k] & (exp_l[k][8] ? 10'h300 : 10'h3FF)) !== exp_l[k]) begin
                    errors++;
                    $display("FAIL stall_log[%0d]: got %h expected %h", k, lg[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_fifo_overflow();
        bit ok;
        logic b;
        logic [9:0] e;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            push_byte(8'(i));
            checks++;
            if (fifo_full !== (i >= 8) || fifo_ovf !== (i == 9)) begin
                errors++;
                $display("FAIL ovf_push%0d: got full=%b ovf=%b expected full=%b ovf=%b",
                         i, fifo_full, fifo_ovf, (i >= 8), (i == 9));
            end
        end
        issue_cmd(7'h11, 4'd8);
        issue_cmd(7'h33, 4'd1);
        wait_done(2000, ok, b);
        checks++;
        if (!ok || b !== 1'b0) begin
            errors++;
            $display("FAIL ovf_done: got ok=%b busy=%b expected ok=1 busy=0", ok, b);
        end
        checks++;
        if (lg.size() != 11) begin
            errors++;
            $display("FAIL ovf_log_len: got %0d expected 11", lg.size());
        end else begin
            for (int k = 0; k < 11; k++) begin
                if (k == 0)       e = 10'h222;
                else if (k == 1)  e = 10'h022;
                else if (k == 10) e = 10'h100;
                else              e = 10'(k - 1);
                checks++;
                if ((lg[k] & (k == 10 ? 10'h300 : 10'h3FF)) !== e) begin
                    errors++;
                    $display("FAIL ovf_log[%0d]: got %h expected %h", k, lg[k], e);
                end
            end
        end
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: got full=%b expected 0", fifo_full);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [15:0] v;
        do_reset();
        push_byte(8'h5A);
        push_byte(8'h6B);
        issue_cmd(7'h10, 4'd2);
        wait_log(3, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_reach_data: got timeout expected data strobe");
        end
        #1;
        reset = 1'b1;
        @(negedge clk);
        v = {busy, done, err, fifo_full, fifo_ovf, bus.i2c_en, bus.i2c_start, bus.i2c_stop, bus.i2c_tx_data};
        checks++;
        if (v !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0000", v);
        end
        reset = 1'b0;
        lg.delete();
        for (int i = 0; i < 7; i++) push_byte(8'hC0);
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fifo_7: got full=%b expected 0", fifo_full);
        end
        push_byte(8'hC7);
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fifo_8: got full=%b expected 1", fifo_full);
        end
        checks++;
        if (lg.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got strobes=%0d busy=%b expected 0 and 0", lg.size(), busy);
        end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        int d0;
        do_reset();
        eng_freeze = 1'b1;
        push_byte(8'h01);
        push_byte(8'h02);
        d0 = done_cnt;
        issue_cmd(7'h40, 4'd2);
        wait_log(1, 100, ok);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (err) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n < 98 || n > 104) begin
            errors++;
            $display("FAIL timeout_err_cycle: got %0d expected about 101", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: got %b expected 0", busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_no_done: got %0d done pulses expected 0", done_cnt - d0);
        end
        eng_freeze = 1'b0;
        eng_on = 1'b0;
        for (int i = 0; i < 7; i++) push_byte(8'hE0);
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flush: got full=%b after 7 pushes expected 0", fifo_full);
        end
        eng_on = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        checks++;
        if (err_cnt != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_err: got %0d err pulses expected 0", err_cnt);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cmd_start = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        test_reset();
        test_basic_write();
        test_addr_only();
        test_stall();
        test_fifo_overflow();
        test_mid_reset();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
